stopwatch_display: RTL and testbench

Four-digit multiplexed 7-segment driver that sits directly downstream of the stopwatch counter and turns its BCD digit outputs (min0, sec1, sec0, milSec0) into time-shared anode and segment drives for an M.SS.m display. A prescaler paces the digit scan. The four inputs are snapshotted once per frame so a displayed frame never mixes old and new digits. Each digit slot starts with a short all-anodes-off guard interval to prevent ghosting.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/bcd_to_seg7.sv | 11 +
 rtl/stopwatch_display.sv | 89 ++++++++
 tb/tb_stopwatch_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared segment constants and digit-index encoding
package stopwatch_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is rightmost, 10..15 render a dash.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDX_MS = 2'd0,
    IDX_S0 = 2'd1,
    IDX_S1 = 2'd2,
    IDX_M0 = 2'd3
  } digit_idx_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low 7-segment pattern
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - four-digit multiplexed 7-segment scan driver
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2,
  parameter int DIV_W    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [3:0] milSec0,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sh_q [4];
  logic [3:0]       sh_d [4];
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end;
  logic             in_guard;
  logic             blank;
  logic [6:0]       dec_seg;

  assign slot_end = (cnt_q == DIV_W'(SCAN_DIV - 1));

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < DIV_W'(GUARD));
    end
  endgenerate

  bcd_to_seg7 u_dec (
    .bcd_i (sh_q[idx_q]),
    .seg_o (dec_seg)
  );

  // lz_blank is deliberately live; only the digit values are frame-coherent.
  assign blank = lz_blank && (idx_q == IDX_M0) && (sh_q[IDX_M0] == 4'd0);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;
    sh_d  = sh_q;
    if (slot_end && (idx_q == IDX_M0)) begin
      sh_d[IDX_MS] = milSec0;
      sh_d[IDX_S0] = sec0;
      sh_d[IDX_S1] = sec1;
      sh_d[IDX_M0] = min0;
    end
    an_d  = in_guard ? AN_OFF : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_OFF : dec_seg;
    dp_d  = blank ? 1'b1 : ~idx_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < 4; i++) sh_q[i] <= 4'd0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - randomized self-checking bench against a frame-level model
module tb_stopwatch_display;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] min0, sec1, sec0, milSec0;
  logic       lz_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  logic [3:0] sh [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  stopwatch_display #(.SCAN_DIV(SD), .GUARD(GD), .DIV_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .min0     (min0),
    .sec1     (sec1),
    .sec0     (sec0),
    .milSec0  (milSec0),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int slot);
    case (slot)
      0: return 4'hE;
      1: return 4'hD;
      2: return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, 16'(an), 16'hF);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dp"}, 16'(dp), 16'h1);
  endtask

  // One clock: model predicts outputs from the elapsed-cycle count k and the frame's shadow values.
  task automatic tick();
    int cnt, slot;
    @(posedge clk);
    cnt  = k % SD;
    slot = (k / SD) % 4;
    e_an = (cnt < GD) ? 4'hF : an_of(slot);
    if (lz_blank && slot == 3 && sh[3] == 4'd0) begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_seg = seg_of(sh[slot]);
      e_dp  = (slot % 2 == 1) ? 1'b0 : 1'b1;
    end
    if (k % FRAME == FRAME - 1) begin
      sh[0] = milSec0;
      sh[1] = sec0;
      sh[2] = sec1;
      sh[3] = min0;
    end
    k++;
    #1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) sh[i] = 4'd0;
  endtask

  initial begin
    int p;
    reset = 1'b0;
    {min0, sec1, sec0, milSec0} = 16'h0;
    lz_blank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");

    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_release");

    {min0, sec1, sec0, milSec0} = {4'd3, 4'd5, 4'd9, 4'd7};
    repeat (FRAME) tick();

    for (int i = 0; i < FRAME; i++) begin
      tick();
      p = k - 1;
      if (p % SD == 4) begin
        case ((p / SD) % 4)
          0: check("f2_ms", 16'(seg), 16'h78);
          1: check("f2_s0", 16'(seg), 16'h10);
          2: check("f2_s1", 16'(seg), 16'h12);
          default: check("f2_m0", 16'(seg), 16'h30);
        endcase
      end
      if (p == FRAME + 8) {min0, sec1, sec0, milSec0} = {4'd1, 4'd2, 4'd3, 4'd4};
    end

    repeat (FRAME - 1) tick();
    {min0, sec1, sec0, milSec0} = {4'd0, 4'd2, 4'hC, 4'd4};
    lz_blank = 1'b1;
    tick();

    for (int i = 0; i < FRAME; i++) begin
      tick();
      p = (k - 1) % FRAME;
      if (p == 12) begin
        check("dash_an", 16'(an), 16'hD);
        check("dash_seg", 16'(seg), 16'h3F);
      end
      if (p == 26) begin
        check("lz_an", 16'(an), 16'h7);
        check("lz_seg", 16'(seg), 16'h7F);
        check("lz_dp", 16'(dp), 16'h1);
      end
      if (p == 27) lz_blank = 1'b0;
      if (p == 29) begin
        check("nolz_seg", 16'(seg), 16'h40);
        check("nolz_dp", 16'(dp), 16'h0);
      end
    end

    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        min0    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        sec1    = 4'($urandom_range(0, 15));
        sec0    = 4'($urandom_range(0, 15));
        milSec0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 4) == 0) lz_blank = 1'($urandom_range(0, 1));
      tick();
    end

    while (k % FRAME != 2 * SD + 5) tick();
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    {min0, sec1, sec0, milSec0} = {4'd8, 4'd6, 4'd1, 4'd2};
    lz_blank = 1'b0;
    #1;
    check_reset_vals("rst_mid_release");
    repeat (FRAME + SD) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
